// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: registered, handshaked memory-mapped I/O decode between the CPU
// memory port and RAM, a bank of output registers and a bank of synchronised
// input ports carrying sticky clear-on-read change flags.
//
// Upper-half address map (offsets from 1 << (ADDR_W-1)):
//   0x00+i  out_reg i        (r/w)
//   0x40+j  synced in_port j (r)
//   0x50+j  change flag j    (r, clear on read)
// Everything else in the upper half is unmapped: reads return 0, writes vanish.

// One input port: 2-flop synchroniser, history flop and sticky change flag.
module mmio_in_lane #(
  parameter int IN_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] pin,
  input  logic            clr,
  output logic [IN_W-1:0] synced,
  output logic            flag
);
  logic [IN_W-1:0] s1, s2, hist;

  // Synchronise, keep one cycle of history; a fresh change beats a read-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      hist <= '0;
      flag <= 1'b0;
    end else begin
      s1   <= pin;
      s2   <= s1;
      hist <= s2;
      if (s2 != hist)
        flag <= 1'b1;
      else if (clr)
        flag <= 1'b0;
    end
  end

  assign synced = s2;
endmodule

module mmio_bus_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 9,
  parameter int RAM_AW  = 8,
  parameter int RAM_LAT = 1,
  parameter int NUM_OUT = 2,
  parameter int OUT_W   = 8,
  parameter int NUM_IN  = 2,
  parameter int IN_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               mem_cmd,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        write_data,
  output logic [DATA_W-1:0]        read_data,
  output logic                     mem_ready,
  output logic [RAM_AW-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_din,
  output logic                     ram_write,
  input  logic [DATA_W-1:0]        ram_dout,
  output logic [NUM_OUT*OUT_W-1:0] out_regs,
  input  logic [NUM_IN*IN_W-1:0]   in_ports
);

  // Parameter legality: any violation stops elaboration.
  if (RAM_LAT < 1 || RAM_LAT > 4) begin : g_bad_lat
    $error("mmio_bus_ctrl: RAM_LAT must be 1..4");
  end
  if (NUM_OUT < 1 || NUM_OUT > 16) begin : g_bad_nout
    $error("mmio_bus_ctrl: NUM_OUT must be 1..16");
  end
  if (NUM_IN < 1 || NUM_IN > 16) begin : g_bad_nin
    $error("mmio_bus_ctrl: NUM_IN must be 1..16");
  end
  if (OUT_W < 1 || OUT_W > DATA_W) begin : g_bad_outw
    $error("mmio_bus_ctrl: OUT_W must be 1..DATA_W");
  end
  if (IN_W < 1 || IN_W > DATA_W) begin : g_bad_inw
    $error("mmio_bus_ctrl: IN_W must be 1..DATA_W");
  end
  if (ADDR_W < 8 || RAM_AW < 1 || RAM_AW > ADDR_W-1) begin : g_bad_aw
    $error("mmio_bus_ctrl: need ADDR_W >= 8 and RAM_AW <= ADDR_W-1");
  end

  localparam int          OFF_W   = ADDR_W - 1;
  localparam logic [31:0] OUT_END = NUM_OUT;
  localparam logic [31:0] IN_BASE = 32'h40;
  localparam logic [31:0] IN_END  = 32'h40 + NUM_IN;
  localparam logic [31:0] FL_BASE = 32'h50;
  localparam logic [31:0] FL_END  = 32'h50 + NUM_IN;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Decoded view of the CPU address; idx is the low nibble, i.e. the
  // register/port number inside whichever upper-half window hit.
  typedef struct packed {
    logic       ram;
    logic       outr;
    logic       inp;
    logic       flg;
    logic [3:0] idx;
  } dec_t;

  state_t                         state_q, state_d;
  dec_t                           dec;
  logic [31:0]                    off32;
  logic                           is_rd, is_wr;
  logic                           accept, capture;
  logic [1:0]                     cnt_q;
  logic [DATA_W-1:0]              rd_val;
  logic [NUM_OUT-1:0][OUT_W-1:0]  out_q;
  logic [NUM_IN-1:0][IN_W-1:0]    in_sync;
  logic [NUM_IN-1:0]              in_flag;
  logic [NUM_IN-1:0]              in_clr;

  assign is_rd    = (mem_cmd == 2'b10);
  assign is_wr    = (mem_cmd == 2'b11);
  assign out_regs = out_q;

  // Address decode; only ever feeds registers, never an output directly.
  always_comb begin
    off32    = 32'(mem_addr[OFF_W-1:0]);
    dec      = '0;
    dec.idx  = mem_addr[3:0];
    dec.ram  = ~mem_addr[ADDR_W-1];
    if (mem_addr[ADDR_W-1]) begin
      dec.outr = (off32 < OUT_END);
      dec.inp  = (off32 >= IN_BASE) && (off32 < IN_END);
      dec.flg  = (off32 >= FL_BASE) && (off32 < FL_END);
    end
  end

  // Register-side read mux, zero-extended; unmapped addresses fall through to 0.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_OUT; i++)
      if (dec.outr && dec.idx == 4'(i)) rd_val[OUT_W-1:0] = out_q[i];
    for (int j = 0; j < NUM_IN; j++) begin
      if (dec.inp && dec.idx == 4'(j)) rd_val[IN_W-1:0] = in_sync[j];
      if (dec.flg && dec.idx == 4'(j)) rd_val[0]        = in_flag[j];
    end
  end

  // Flag clear strobes: only an accepted read of the flag window clears.
  always_comb begin
    in_clr = '0;
    for (int j = 0; j < NUM_IN; j++)
      in_clr[j] = accept && is_rd && dec.flg && (dec.idx == 4'(j));
  end

  genvar gj;
  for (gj = 0; gj < NUM_IN; gj++) begin : g_in
    mmio_in_lane #(.IN_W(IN_W)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .pin    (in_ports[gj*IN_W +: IN_W]),
      .clr    (in_clr[gj]),
      .synced (in_sync[gj]),
      .flag   (in_flag[gj])
    );
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state plus accept/capture strobes. DONE always burns one cycle so
  // mem_ready can never be asserted on two consecutive cycles.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: if (mem_cmd[1]) begin
        accept  = 1'b1;
        state_d = (is_rd && dec.ram) ? WAIT : DONE;
      end
      WAIT: if (cnt_q == 2'd0) begin
        capture = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath. Writes and register reads complete on the accept edge. RAM
  // reads drive ram_addr from the accept edge and sample ram_dout on the
  // RAM_LAT-th following edge, so mem_ready lands RAM_LAT+1 cycles after accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b0;
      ram_write <= 1'b0;
      read_data <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      out_q     <= '0;
      cnt_q     <= '0;
    end else begin
      mem_ready <= 1'b0;
      ram_write <= 1'b0;
      if (accept) begin
        if (dec.ram) begin
          ram_addr <= mem_addr[RAM_AW-1:0];
          if (is_wr) begin
            ram_din   <= write_data;
            ram_write <= 1'b1;
            mem_ready <= 1'b1;
          end else begin
            cnt_q <= 2'(RAM_LAT - 1);
          end
        end else begin
          mem_ready <= 1'b1;
          if (is_wr) begin
            for (int i = 0; i < NUM_OUT; i++)
              if (dec.outr && dec.idx == 4'(i)) out_q[i] <= write_data[OUT_W-1:0];
          end else begin
            read_data <= rd_val;
          end
        end
      end
      if (state_q == WAIT && cnt_q != 2'd0)
        cnt_q <= cnt_q - 2'd1;
      if (capture) begin
        read_data <= ram_dout;
        mem_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Scoreboard bench for mmio_bus_ctrl: two instances (RAM_LAT=3 and RAM_LAT=1),
// each with a behavioural RAM; the driver pushes expected completions and a
// negedge monitor pops and compares on every mem_ready.
module tb_mmio_bus_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          is_rd;
    logic [15:0] rd;
    bit          wr_ram;
    logic [7:0]  ra;
    logic [15:0] rdin;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // ---- DUT A: RAM_LAT = 3 ----
  logic [1:0]  cmd_a;
  logic [8:0]  addr_a;
  logic [15:0] wd_a, rd_a, din_a, dout_a, out_a;
  logic        rdy_a, rw_a;
  logic [7:0]  ra_a;
  // ---- DUT B: RAM_LAT = 1 ----
  logic [1:0]  cmd_b;
  logic [8:0]  addr_b;
  logic [15:0] wd_b, rd_b, din_b, dout_b, out_b;
  logic        rdy_b, rw_b;
  logic [7:0]  ra_b;

  logic [15:0] in_ports;

  mmio_bus_ctrl #(.RAM_LAT(3)) u_a (
    .clk(clk), .reset(reset), .mem_cmd(cmd_a), .mem_addr(addr_a),
    .write_data(wd_a), .read_data(rd_a), .mem_ready(rdy_a),
    .ram_addr(ra_a), .ram_din(din_a), .ram_write(rw_a), .ram_dout(dout_a),
    .out_regs(out_a), .in_ports(in_ports)
  );

  mmio_bus_ctrl #(.RAM_LAT(1)) u_b (
    .clk(clk), .reset(reset), .mem_cmd(cmd_b), .mem_addr(addr_b),
    .write_data(wd_b), .read_data(rd_b), .mem_ready(rdy_b),
    .ram_addr(ra_b), .ram_din(din_b), .ram_write(rw_b), .ram_dout(dout_b),
    .out_regs(out_b), .in_ports(in_ports)
  );

  // Reference state (what the CPU should observe).
  logic [15:0] ref_ram_a [256];
  logic [15:0] ref_ram_b [256];
  logic [7:0]  ref_out_a [2];
  logic [7:0]  ref_out_b [2];
  logic [7:0]  ref_last  [2];
  bit          ref_flag  [2];

  // Environment RAMs: A returns data two cycles after ram_addr, B combinationally.
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic        mem_init;
  logic [7:0]  ap_a0, ap_a1;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= ref_ram_a[i];
        mem_b[i] <= ref_ram_b[i];
      end
    end else begin
      if (rw_a) mem_a[ra_a] <= din_a;
      if (rw_b) mem_b[ra_b] <= din_b;
    end
    ap_a0 <= ra_a;
    ap_a1 <= ap_a0;
  end
  assign dout_a = mem_a[ap_a1];
  assign dout_b = mem_b[ra_b];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitor A
  logic prev_a = 1'b0;
  exp_t ea;
  always @(negedge clk) begin
    if (rdy_a) begin
      if (q_a.size() == 0) fail("unexpected_ready_a");
      else begin
        ea = q_a.pop_front();
        chk("latency_a", cyc, ea.cyc);
        if (ea.is_rd) chk("read_data_a", rd_a, ea.rd);
        chk("ram_write_a", rw_a, ea.wr_ram);
        if (ea.wr_ram) begin
          chk("ram_addr_a", ra_a, ea.ra);
          chk("ram_din_a", din_a, ea.rdin);
        end
      end
      chk("ready_gap_a", prev_a, 0);
    end else if (rw_a) fail("ram_write_without_ready_a");
    prev_a <= rdy_a;
  end

  // Monitor B
  logic prev_b = 1'b0;
  exp_t eb;
  always @(negedge clk) begin
    if (rdy_b) begin
      if (q_b.size() == 0) fail("unexpected_ready_b");
      else begin
        eb = q_b.pop_front();
        chk("latency_b", cyc, eb.cyc);
        if (eb.is_rd) chk("read_data_b", rd_b, eb.rd);
        chk("ram_write_b", rw_b, eb.wr_ram);
        if (eb.wr_ram) begin
          chk("ram_addr_b", ra_b, eb.ra);
          chk("ram_din_b", din_b, eb.rdin);
        end
      end
      chk("ready_gap_b", prev_b, 0);
    end else if (rw_b) fail("ram_write_without_ready_b");
    prev_b <= rdy_b;
  end

  // One CPU transaction on DUT d (0=A, 1=B); called just after a posedge with the DUT idle.
  task automatic do_txn(input bit d, input bit wr, input logic [8:0] a, input logic [15:0] wd);
    exp_t e;
    bit   got;
    int   lat;
    lat      = d ? 1 : 3;
    e.cyc    = cyc + 1 + ((!wr && !a[8]) ? lat : 0);
    e.is_rd  = !wr;
    e.rd     = 16'h0;
    e.wr_ram = 1'b0;
    e.ra     = 8'h0;
    e.rdin   = 16'h0;
    if (!a[8]) begin
      if (wr) begin
        e.wr_ram = 1'b1;
        e.ra     = a[7:0];
        e.rdin   = wd;
        if (d) ref_ram_b[a[7:0]] = wd; else ref_ram_a[a[7:0]] = wd;
      end else begin
        e.rd = d ? ref_ram_b[a[7:0]] : ref_ram_a[a[7:0]];
      end
    end else if (a[7:0] < 8'd2) begin
      if (wr) begin
        if (d) ref_out_b[a[0]] = wd[7:0]; else ref_out_a[a[0]] = wd[7:0];
      end else begin
        e.rd = {8'h00, d ? ref_out_b[a[0]] : ref_out_a[a[0]]};
      end
    end else if (!d && (a[7:0] == 8'h40 || a[7:0] == 8'h41)) begin
      e.rd = {8'h00, ref_last[a[0]]};
    end else if (!d && (a[7:0] == 8'h50 || a[7:0] == 8'h51)) begin
      if (!wr) begin
        e.rd = {15'h0, ref_flag[a[0]]};
        ref_flag[a[0]] = 1'b0;
      end
    end
    if (d) q_b.push_back(e); else q_a.push_back(e);
    if (d) begin cmd_b = wr ? 2'b11 : 2'b10; addr_b = a; wd_b = wd; end
    else   begin cmd_a = wr ? 2'b11 : 2'b10; addr_a = a; wd_a = wd; end
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (d ? rdy_b : rdy_a) got = 1'b1;
    end
    if (!got) begin
      fail(d ? "timeout_b" : "timeout_a");
      if (d) q_b.delete(); else q_a.delete();
    end
    @(posedge clk);
    #1;
    if (d) cmd_b = 2'b00; else cmd_a = 2'b00;
    if (d) chk("out_regs_b", out_b, {ref_out_b[1], ref_out_b[0]});
    else   chk("out_regs_a", out_a, {ref_out_a[1], ref_out_a[0]});
  endtask

  // Change the input pins and let them settle through the synchroniser.
  task automatic set_inputs(input logic [15:0] v);
    in_ports = v;
    repeat (4) @(posedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      if (v[j*8 +: 8] != ref_last[j]) ref_flag[j] = 1'b1;
      ref_last[j] = v[j*8 +: 8];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ref_out_a[i] = 8'h0;
      ref_out_b[i] = 8'h0;
      ref_last[i]  = 8'h0;
      ref_flag[i]  = 1'b0;
    end
  endtask

  int          r;
  bit          wr;
  logic [8:0]  a;
  logic [15:0] wd;

  initial begin
    reset = 1'b1; mem_init = 1'b1; in_ports = 16'h0;
    cmd_a = 2'b00; addr_a = 9'h0; wd_a = 16'h0;
    cmd_b = 2'b00; addr_b = 9'h0; wd_b = 16'h0;
    for (int i = 0; i < 256; i++) begin
      ref_ram_a[i] = 16'($urandom);
      ref_ram_b[i] = 16'($urandom);
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    @(negedge clk);
    chk("reset_ready_a", rdy_a, 0);
    chk("reset_rdata_a", rd_a, 0);
    chk("reset_out_a", out_a, 0);
    chk("reset_ramwr_a", rw_a, 0);
    chk("reset_out_b", out_b, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Output register write/read.
    do_txn(0, 1, 9'h100, 16'h00A5);
    do_txn(0, 0, 9'h100, 16'h0);
    do_txn(0, 1, 9'h101, 16'hFF3C);
    do_txn(0, 0, 9'h101, 16'h0);
    // RAM at both latencies.
    do_txn(0, 1, 9'h012, 16'hBEEF);
    do_txn(0, 0, 9'h012, 16'h0);
    do_txn(1, 1, 9'h012, 16'hBEEF);
    do_txn(1, 0, 9'h012, 16'h0);
    do_txn(1, 1, 9'h0FF, 16'h1234);
    do_txn(1, 0, 9'h0FF, 16'h0);
    // Input port, flag set then clear-on-read.
    set_inputs(16'h003C);
    do_txn(0, 0, 9'h140, 16'h0);
    do_txn(0, 0, 9'h150, 16'h0);
    do_txn(0, 0, 9'h150, 16'h0);
    do_txn(0, 1, 9'h150, 16'hFFFF);
    // Change lands on the flag the same edge the read clears it: set wins.
    set_inputs(16'h0055);
    in_ports = 16'h00AA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_txn(0, 0, 9'h150, 16'h0);
    ref_flag[0] = 1'b1;
    ref_last[0] = 8'hAA;
    do_txn(0, 0, 9'h150, 16'h0);
    do_txn(0, 0, 9'h150, 16'h0);
    do_txn(0, 0, 9'h140, 16'h0);
    // Unmapped.
    do_txn(0, 0, 9'h1F0, 16'h0);
    do_txn(0, 1, 9'h1F0, 16'hDEAD);
    do_txn(0, 1, 9'h102, 16'hDEAD);

    // Randomised traffic on A.
    for (int n = 0; n < 120; n++) begin
      r  = $urandom_range(0, 9);
      wr = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      case (r)
        0, 1, 2: a = 9'($urandom_range(0, 15));
        3, 4:    a = 9'h100 + 9'($urandom_range(0, 1));
        5:       a = 9'h140 + 9'($urandom_range(0, 1));
        6:       a = 9'h150 + 9'($urandom_range(0, 1));
        7:       a = ($urandom_range(0, 1) == 1) ? 9'h160 + 9'($urandom_range(0, 159))
                                                 : 9'h142 + 9'($urandom_range(0, 13));
        default: a = 9'($urandom_range(0, 255));
      endcase
      if (r == 8 && wr) set_inputs(16'($urandom));
      else do_txn(0, wr, a, wd);
    end
    // Randomised traffic on B.
    for (int n = 0; n < 30; n++) begin
      wr = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      a  = ($urandom_range(0, 2) == 0) ? 9'h100 + 9'($urandom_range(0, 1))
                                       : 9'($urandom_range(0, 7));
      do_txn(1, wr, a, wd);
    end

    // Reset while A waits on a RAM read: no completion, everything cleared.
    do_txn(0, 1, 9'h101, 16'h0077);
    cmd_a = 2'b10; addr_a = 9'h012;
    @(posedge clk);
    #1;
    reset = 1'b1; cmd_a = 2'b00;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_ready_a", rdy_a, 0);
    chk("midreset_rdata_a", rd_a, 0);
    chk("midreset_raddr_a", ra_a, 0);
    chk("midreset_rdin_a", din_a, 0);
    chk("midreset_out_a", out_a, 0);
    chk("midreset_ramwr_a", rw_a, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    set_inputs(in_ports);
    repeat (4) @(posedge clk);
    #1;
    do_txn(0, 0, 9'h012, 16'h0);
    do_txn(0, 0, 9'h150, 16'h0);
    do_txn(0, 0, 9'h101, 16'h0);
    do_txn(1, 0, 9'h012, 16'h0);

    repeat (3) @(posedge clk);
    if (q_a.size() != 0 || q_b.size() != 0) fail("scoreboard_not_drained");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
